// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter/sequencer for the 32x8 synchronous-read data memory
module mem_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t              state, state_nxt;
    logic                owner, owner_nxt;
    logic                last_grant, last_grant_nxt;
    logic                op_rd, op_rd_nxt;
    logic                grant;
    logic                ack0_nxt, ack1_nxt;
    logic                mem_rd_nxt, mem_wr_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [DATA_W-1:0]   mem_wdata_nxt;
    logic [DATA_W-1:0]   rdata_nxt;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            op_rd      <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            op_rd      <= op_rd_nxt;
            ack0       <= ack0_nxt;
            ack1       <= ack1_nxt;
            mem_rd     <= mem_rd_nxt;
            mem_wr     <= mem_wr_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            rdata      <= rdata_nxt;
        end
    end

    // On a tie, round-robin hands the grant to the port that did not win last time.
    always_comb begin
        if (req0 && req1)
            grant = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        else
            grant = req1;
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        op_rd_nxt      = op_rd;
        ack0_nxt       = 1'b0;
        ack1_nxt       = 1'b0;
        mem_rd_nxt     = mem_rd;
        mem_wr_nxt     = mem_wr;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        rdata_nxt      = rdata;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    owner_nxt      = grant;
                    last_grant_nxt = grant;
                    op_rd_nxt      = grant ? ~we1 : ~we0;
                    mem_rd_nxt     = grant ? ~we1 : ~we0;
                    mem_wr_nxt     = grant ? we1 : we0;
                    mem_addr_nxt   = grant ? addr1 : addr0;
                    mem_wdata_nxt  = grant ? wdata1 : wdata0;
                    state_nxt      = ISSUE;
                end
            end
            ISSUE: begin
                mem_rd_nxt = 1'b0;
                mem_wr_nxt = 1'b0;
                state_nxt  = RESP;
            end
            RESP: begin
                if (op_rd)
                    rdata_nxt = mem_rdata;
                ack0_nxt  = ~owner;
                ack1_nxt  = owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed table-driven bench for mem_arbiter with behavioural 32x8 memories
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    // Round-robin instance
    logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [4:0] addr0 = 0, addr1 = 0;
    logic [7:0] wdata0 = 0, wdata1 = 0;
    logic       ack0, ack1, busy, mem_rd, mem_wr;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata, rdata;

    // Fixed-priority instance
    logic       f_req0 = 0, f_we0 = 0, f_req1 = 0, f_we1 = 0;
    logic [4:0] f_addr0 = 0, f_addr1 = 0;
    logic [7:0] f_wdata0 = 0, f_wdata1 = 0;
    logic       f_ack0, f_ack1, f_busy, f_mem_rd, f_mem_wr;
    logic [4:0] f_mem_addr;
    logic [7:0] f_mem_wdata, f_mem_rdata, f_rdata;

    logic [7:0] mem0 [32];
    logic [7:0] mem1 [32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(5), .DATA_W(8), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .busy(busy),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(5), .DATA_W(8), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst),
        .req0(f_req0), .we0(f_we0), .addr0(f_addr0), .wdata0(f_wdata0), .ack0(f_ack0),
        .req1(f_req1), .we1(f_we1), .addr1(f_addr1), .wdata1(f_wdata1), .ack1(f_ack1),
        .rdata(f_rdata), .busy(f_busy),
        .mem_rd(f_mem_rd), .mem_wr(f_mem_wr), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem0[i] <= 8'h00;
            mem_rdata <= 8'h00;
        end else begin
            if (mem_wr) mem0[mem_addr] <= mem_wdata;
            if (mem_rd) mem_rdata <= mem0[mem_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem1[i] <= 8'h00;
            f_mem_rdata <= 8'h00;
        end else begin
            if (f_mem_wr) mem1[f_mem_addr] <= f_mem_wdata;
            if (f_mem_rd) f_mem_rdata <= mem1[f_mem_addr];
        end
    end

    typedef struct {
        int         port;
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        @(negedge clk);
        if (v.port == 0) begin
            req0 = 1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
        end else begin
            req1 = 1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
        end
        step();
        chk($sformatf("v%0d_grant_busy", idx), 32'(busy), 32'd1);
        chk($sformatf("v%0d_grant_wr", idx), 32'(mem_wr), 32'(v.we));
        chk($sformatf("v%0d_grant_rd", idx), 32'(mem_rd), 32'(!v.we));
        chk($sformatf("v%0d_grant_addr", idx), 32'(mem_addr), 32'(v.addr));
        if (v.we) chk($sformatf("v%0d_grant_wdata", idx), 32'(mem_wdata), 32'(v.wdata));
        step();
        chk($sformatf("v%0d_issue_ctrl", idx), 32'({mem_rd, mem_wr}), 32'd0);
        chk($sformatf("v%0d_issue_ack", idx), 32'({ack0, ack1}), 32'd0);
        step();
        chk($sformatf("v%0d_resp_ack", idx), 32'({ack0, ack1}), (v.port == 0) ? 32'd2 : 32'd1);
        chk($sformatf("v%0d_resp_rdata", idx), 32'(rdata), 32'(v.exp_rdata));
        req0 = 0;
        req1 = 0;
        step();
        chk($sformatf("v%0d_after_ack", idx), 32'({ack0, ack1, busy}), 32'd0);
    endtask

    initial begin
        int gseq[$];
        int acks;
        vecs[0] = '{0, 1'b1, 5'd3, 8'hA5, 8'h00};
        vecs[1] = '{0, 1'b0, 5'd3, 8'h00, 8'hA5};
        vecs[2] = '{1, 1'b1, 5'd1, 8'h11, 8'hA5};
        vecs[3] = '{0, 1'b1, 5'd2, 8'h22, 8'hA5};
        vecs[4] = '{1, 1'b0, 5'd1, 8'h00, 8'h11};
        vecs[5] = '{0, 1'b1, 5'd4, 8'h44, 8'h11};
        vecs[6] = '{1, 1'b1, 5'd9, 8'h99, 8'h11};
        vecs[7] = '{1, 1'b0, 5'd2, 8'h00, 8'h22};

        #1 rst = 1;
        #1;
        chk("reset_ctrl", 32'({ack0, ack1, busy, mem_rd, mem_wr}), 32'd0);
        chk("reset_data", 32'({mem_addr, mem_wdata, rdata}), 32'd0);
        chk("reset_fp_ctrl", 32'({f_ack0, f_ack1, f_busy, f_mem_rd, f_mem_wr}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 0;

        foreach (vecs[i]) run_txn(vecs[i], i);

        // Contention, round-robin: both held, last winner was port 1
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 5'd1;
        req1 = 1; we1 = 0; addr1 = 5'd2;
        for (int c = 0; c < 20 && gseq.size() < 4; c++) begin
            step();
            chk("rr_exclusive", 32'(ack0 & ack1), 32'd0);
            if (ack0) begin
                gseq.push_back(0);
                chk("rr_rdata0", 32'(rdata), 32'h11);
            end
            if (ack1) begin
                gseq.push_back(1);
                chk("rr_rdata1", 32'(rdata), 32'h22);
            end
        end
        req0 = 0;
        req1 = 0;
        chk("rr_count", 32'(gseq.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < gseq.size()) chk($sformatf("rr_order%0d", k), 32'(gseq[k]), 32'(k % 2));
        step();

        // Port 1 write queued behind a port 0 read, then port 0 reads it back
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 5'd4;
        step();
        chk("q_busy", 32'(busy), 32'd1);
        req1 = 1; we1 = 1; addr1 = 5'd7; wdata1 = 8'h5A;
        step();
        step();
        chk("q_ack0_first", 32'({ack0, ack1}), 32'd2);
        chk("q_rdata_first", 32'(rdata), 32'h44);
        addr0 = 5'd7;
        step();
        chk("q_p1_grant", 32'({mem_wr, mem_rd, mem_addr}), 32'({1'b1, 1'b0, 5'd7}));
        step();
        step();
        chk("q_ack1", 32'({ack0, ack1}), 32'd1);
        req1 = 0;
        step();
        chk("q_p0_grant", 32'({mem_wr, mem_rd, mem_addr}), 32'({1'b0, 1'b1, 5'd7}));
        step();
        step();
        chk("q_ack0_second", 32'({ack0, ack1}), 32'd2);
        chk("q_rdata_5a", 32'(rdata), 32'h5A);
        req0 = 0;
        step();
        chk("q_idle", 32'({ack0, ack1, busy}), 32'd0);

        // Request fields sampled only at the grant edge
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 5'd4;
        step();
        chk("hold_addr_grant", 32'(mem_addr), 32'd4);
        addr0 = 5'd9;
        step();
        chk("hold_addr_issue", 32'(mem_addr), 32'd4);
        step();
        chk("hold_ack", 32'(ack0), 32'd1);
        chk("hold_rdata", 32'(rdata), 32'h44);
        req0 = 0;
        step();

        // Reset during ISSUE of a read
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 5'd4;
        step();
        chk("rst_pre_rd", 32'(mem_rd), 32'd1);
        rst = 1;
        #1;
        chk("rst_mid_ctrl", 32'({busy, mem_rd, ack0, ack1}), 32'd0);
        chk("rst_mid_rdata", 32'(rdata), 32'd0);
        req0 = 0;
        @(negedge clk) rst = 0;
        acks = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (ack0 || ack1) acks++;
        end
        chk("rst_no_ack", 32'(acks), 32'd0);
        run_txn('{0, 1'b1, 5'd3, 8'h3C, 8'h00}, 8);
        run_txn('{0, 1'b0, 5'd3, 8'h00, 8'h3C}, 9);

        // Fixed priority: port 1 starves while port 0 holds its request
        @(negedge clk);
        f_req0 = 1; f_we0 = 0; f_addr0 = 5'd0;
        f_req1 = 1; f_we1 = 1; f_addr1 = 5'd5; f_wdata1 = 8'h77;
        acks = 0;
        for (int c = 0; c < 20 && acks < 3; c++) begin
            step();
            chk("fp_no_ack1", 32'(f_ack1), 32'd0);
            if (f_ack0) acks++;
        end
        chk("fp_ack0_count", 32'(acks), 32'd3);
        f_req0 = 0;
        step();
        chk("fp_p1_grant", 32'({f_mem_wr, f_mem_addr, f_mem_wdata}), 32'({1'b1, 5'd5, 8'h77}));
        step();
        step();
        chk("fp_ack1", 32'({f_ack0, f_ack1}), 32'd1);
        f_req1 = 0;
        step();
        chk("fp_idle", 32'({f_ack0, f_ack1, f_busy}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer for the 32x8 synchronous-read data memory.
- Serialises read/write requests from the instruction-fetch side (port 0) and the load/store side (port 1) onto the memory's single rd/wr/addr/data port.
- Registers all memory-side controls, captures read data one cycle after the memory's registered output, and returns a one-cycle ack to the owning requester.

Parameters:
ADDR_W, 5, memory address width (32 locations)
DATA_W, 8, data width
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins contention

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req0  in  1  port 0 request; held until ack0
we0  in  1  port 0 write (1) / read (0)
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  port 0 transaction complete, one-cycle pulse
req1  in  1  port 1 request; held until ack1
we1  in  1  port 1 write / read
addr1  in  ADDR_W  port 1 address
wdata1  in  DATA_W  port 1 write data
ack1  out  1  port 1 transaction complete, one-cycle pulse
rdata  out  DATA_W  read data; valid while ack0/ack1 high for a read
busy  out  1  transaction in flight (state != IDLE)
mem_rd  out  1  to memory rd
mem_wr  out  1  to memory wr
mem_addr  out  ADDR_W  to memory addr
mem_wdata  out  DATA_W  to memory data_in
mem_rdata  in  DATA_W  from memory data_out (registered in memory, 1-cycle latency)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - ack0, ack1, mem_rd, mem_wr = 0; mem_addr, mem_wdata, rdata = 0; busy = 0.
  - last_grant = 1, so port 0 wins the first tie.
- All outputs are registered; there is no combinational path from req to the mem_* outputs.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that port.
  - Both requests with FIXED_PRIO=0: grant the port != last_grant.
  - Both requests with FIXED_PRIO=1: grant port 0.
  - On grant, at the same edge: latch owner and update last_grant = owner; mem_addr = addrN; mem_wdata = wdataN; mem_rd = ~weN; mem_wr = weN; state -> ISSUE.
- ISSUE:
  - The memory samples rd/wr at this edge.
  - Arbiter clears mem_rd and mem_wr; mem_addr and mem_wdata hold; state -> RESP.
- RESP:
  - mem_rdata is valid for a read.
  - At the edge: rdata = mem_rdata (read) or holds its previous value (write); ackN = 1 for the owner only; state -> IDLE.
- Ack:
  - Pulses for exactly one cycle; cleared at the next edge.
  - A requester drops req during its ack cycle. If req is still high at the next IDLE edge, it is treated as a new request.
- Latency: request sampled at edge E0 -> ack high from E2 to E3. One transaction per 3 cycles; no pipelining.
- Request fields are sampled only at the grant edge; later changes to addrN/wdataN/weN have no effect on the transaction in flight.
- A request arriving while busy waits in its port; it is never dropped and never acked early.
- Starvation bound (round-robin): a continuously asserted request is served within 2 transactions.
- rdata holds its last read value between transactions.
- Reset mid-transaction: immediate return to IDLE, no ack is issued, and mem_rd/mem_wr deassert. rst is shared with the memory, so memory contents are also cleared.
- Read and write to the same address by different ports are strictly ordered by grant order; there is no forwarding.

Test Plan:
- Port 0 writes 0xA5 to addr 3, then reads addr 3 -> mem_wr pulses 1 cycle with mem_addr=3 and mem_wdata=0xA5; each ack0 arrives 2 cycles after req is sampled; read returns rdata=0xA5 on ack0.
- req0 and req1 held together, both reading addrs 1/2 preloaded 0x11/0x22, FIXED_PRIO=0 -> grants alternate 0,1,0,1; rdata 0x11 on ack0 and 0x22 on ack1; ack1 never high with ack0.
- Same contention with FIXED_PRIO=1 and req0 held continuously -> port 1 not served while req0 is high; served on the first IDLE edge after req0 drops.
- req1 issues a write of 0x5A to addr 7 while port 0 is busy; port 0 then reads 7 -> port 1 write completes first (ack1); port 0 read returns 0x5A.
- Assert rst during ISSUE of a read -> no ack; busy=0, mem_rd=0, rdata=0 immediately; next request completes normally with 3-cycle latency.
- Change addr0 from 4 to 9 one cycle after grant -> mem_addr stays 4; returned data is mem[4].
